// File: rtl/idu_imm_sched_if.sv
// IFU-side and EXU-side valid/ready bundle for the decode-stage immediate sequencer.
// The slave modport is the sequencer; the master modport is the IFU/EXU environment.
interface idu_imm_sched_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_pc;
   logic [W-1:0] in_inst;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_pc;
   logic [W-1:0] out_inst;
   logic [W-1:0] out_imm;
   logic [2:0]   out_imm_type;
   logic         out_illegal;

   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_imm, out_imm_type, out_illegal
   );

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_imm, out_imm_type, out_illegal
   );
endinterface

// File: rtl/idu_imm_sched.sv
// Decode-stage sequencer: opcode -> imm type, drives the imm decoder, 2-entry skid buffer to EXU.
// Optional macro IDU_ILLEGAL_TRAP_EN keeps an illegal-opcode bit per entry; otherwise out_illegal=0.
//
// state | meaning
// EMPTY | no entries buffered, out_valid=0
// ONE   | one entry buffered, can push and pop
// FULL  | two entries buffered, in_ready=0
module idu_imm_sched #(
   parameter int W           = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   idu_imm_sched_if.slave         bus,
   output logic [W-1:0]           dec_cmd_o,
   output logic [2:0]             dec_op_imm_o,
   input  logic [W-1:0]           dec_imm_i,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);
   // Immediate type codes shared with the imm decoder
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_U = 3'd1;
   localparam logic [2:0] IMM_J = 3'd2;
   localparam logic [2:0] IMM_S = 3'd3;
   localparam logic [2:0] IMM_B = 3'd4;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

   state_e                   state_q, state_d;
   logic                     wr_ptr_q, wr_ptr_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic                     rdy_en_q;
   logic [STALL_CNT_W-1:0]   stall_q;
   logic [W-1:0]             pc_q   [2];
   logic [W-1:0]             inst_q [2];
   logic [W-1:0]             imm_q  [2];
   logic [2:0]               type_q [2];
   logic                     push, pop;
   logic [2:0]               op_imm;

   always_comb begin
      op_imm = IMM_I;
      case (bus.in_inst[6:0])
         7'b0110111, 7'b0010111: op_imm = IMM_U;
         7'b1101111:             op_imm = IMM_J;
         7'b1100011:             op_imm = IMM_B;
         7'b0100011:             op_imm = IMM_S;
         default:                op_imm = IMM_I;
      endcase
   end

   assign dec_cmd_o    = bus.in_inst;
   assign dec_op_imm_o = op_imm;

   // rdy_en_q keeps in_ready low while reset is asserted and for the release cycle
   assign bus.in_ready  = (state_q != FULL) && !flush_i && rdy_en_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
      if (flush_i) begin
         state_d  = EMPTY;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
               if (push && !pop)      state_d = FULL;
               else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_en_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
            imm_q[i]  <= '0;
            type_q[i] <= IMM_I;
         end
      end else if (push) begin
         pc_q[wr_ptr_q]   <= bus.in_pc;
         inst_q[wr_ptr_q] <= bus.in_inst;
         imm_q[wr_ptr_q]  <= dec_imm_i;
         type_q[wr_ptr_q] <= op_imm;
      end
   end

   assign bus.out_pc       = pc_q[rd_ptr_q];
   assign bus.out_inst     = inst_q[rd_ptr_q];
   assign bus.out_imm      = imm_q[rd_ptr_q];
   assign bus.out_imm_type = type_q[rd_ptr_q];

`ifdef IDU_ILLEGAL_TRAP_EN
   logic op_legal;
   logic ill_q [2];

   always_comb begin
      op_legal = 1'b0;
      case (bus.in_inst[6:0])
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0100011,
         7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0110011: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_q[0] <= 1'b0;
         ill_q[1] <= 1'b0;
      end else if (push) begin
         ill_q[wr_ptr_q] <= !op_legal;
      end
   end

   assign bus.out_illegal = ill_q[rd_ptr_q];
`else
   assign bus.out_illegal = 1'b0;
`endif

   // Saturating count of cycles the EXU holds off a valid head entry; survives flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt_o = stall_q;
endmodule
